seg7_result_scanner: RTL and testbench

//  Downstream consumer of the processor's 16-bit `result` bus. Drives a 4-digit

---
 rtl/seg7_result_scanner.sv | 129 ++++++++++++
 tb/tb_seg7_result_scanner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_result_scanner.sv
// seg7_result_scanner: 4-digit multiplexed hex display of the result bus.
// Snapshots on frame wrap, supports hold, leading-zero blanking and DP flash.
module seg7_result_scanner #(
  parameter int SCAN_BITS    = 16,
  parameter int FLASH_CYCLES = 1 << 20,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] result,
  input  logic        hold,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int FW = $clog2(FLASH_CYCLES + 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);

  logic [SCAN_BITS-1:0] cnt;
  logic [15:0]          result_q;
  logic [15:0]          disp_val;
  logic [FW-1:0]        flash_cnt;

  logic [1:0] dig;
  logic       wrap;
  logic       snap;
  logic       changed;
  logic [3:0] nib;
  logic [3:0] lz;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  assign dig     = cnt[SCAN_BITS-1 -: 2];
  assign wrap    = &cnt;
  assign snap    = wrap & ~hold;
  assign changed = result_q != disp_val;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Select the nibble of the frozen value for the digit being scanned.
  always_comb begin
    nib = disp_val[3:0];
    case (dig)
      2'd0: nib = disp_val[3:0];
      2'd1: nib = disp_val[7:4];
      2'd2: nib = disp_val[11:8];
      default: nib = disp_val[15:12];
    endcase
  end

  // Leading-zero mask: a digit blanks only if it and all higher are zero.
  always_comb begin
    lz    = 4'b0000;
    lz[3] = BLANK_LZ && (disp_val[15:12] == 4'h0);
    lz[2] = lz[3] && (disp_val[11:8] == 4'h0);
    lz[1] = lz[2] && (disp_val[7:4] == 4'h0);
    lz[0] = 1'b0;
  end

  // Next-state output drive, registered below so no input reaches a pin.
  always_comb begin
    an_next  = ~(4'b0001 << dig) | lz;
    seg_next = hex7(nib);
    dp_next  = (flash_cnt == '0);
  end

  // Refresh counter; the all-ones value marks the frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + 1'b1;
  end

  // Capture stage for the bus coming from the divided clock domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result_q <= '0;
    else        result_q <= result;
  end

  // Frame-aligned snapshot so a digit never changes mid-frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    disp_val <= '0;
    else if (snap) disp_val <= result_q;
  end

  // DP flash timer: reload on a real change, otherwise count down to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 flash_cnt <= '0;
    else if (snap && changed)   flash_cnt <= FLASH_LOAD;
    else if (flash_cnt != '0)   flash_cnt <= flash_cnt - 1'b1;
  end

  // Registered display pins; reset blanks everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_result_scanner.sv
// tb_seg7_result_scanner: scoreboard bench for the 7-segment scanner.
// Reference model predicts pin values per clock; monitor checks at negedge.
module tb_seg7_result_scanner;

  localparam int SB = 4;
  localparam int FL = 8;
  localparam int FRAME = 1 << SB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] result = 16'h0;
  logic        hold = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          m_t = 0;
  logic [15:0] m_disp = 0;
  logic [15:0] m_rq = 0;
  int          m_flash = 0;

  seg7_result_scanner #(
    .SCAN_BITS(SB),
    .FLASH_CYCLES(FL),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .result(result),
    .hold(hold),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic exp_t blank_exp();
    exp_t e;
    e.an = 4'hF;
    e.seg = 7'h7F;
    e.dp = 1'b1;
    return e;
  endfunction

  task automatic model_clear();
    m_t = 0;
    m_disp = 0;
    m_rq = 0;
    m_flash = 0;
  endtask

  // One clock edge of the reference: predict pins, then advance state.
  task automatic tick();
    exp_t e;
    int dig;
    int nd;
    @(posedge clk);
    if (!reset) begin
      e = blank_exp();
      model_clear();
    end else begin
      dig = (m_t % FRAME) / (FRAME / 4);
      nd = 1;
      while (nd < 4 && (m_disp >> (4 * nd)) != 0) nd++;
      e.an = (dig < nd) ? ~(4'b0001 << dig) : 4'hF;
      e.seg = hex_tab[(m_disp >> (4 * dig)) & 16'hF];
      e.dp = (m_flash == 0);
      if (m_flash > 0) m_flash--;
      if (m_t == FRAME - 1 && !hold) begin
        if (m_rq != m_disp) m_flash = FL;
        m_disp = m_rq;
      end
      m_rq = result;
      m_t = (m_t + 1) % FRAME;
    end
    q.push_back(e);
  endtask

  task automatic run(input logic [15:0] r, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      #1;
      result = r;
      hold = h;
    end
  endtask

  // Async reset lands mid-cycle: the current prediction becomes blank.
  task automatic async_reset();
    void'(q.pop_back());
    q.push_back(blank_exp());
    model_clear();
    reset = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every displayed cycle is matched against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an", int'(an), int'(e.an));
        chk("seg", int'(seg), int'(e.seg));
        chk("dp", int'(dp), int'(e.dp));
      end
    end
  end

  initial begin
    logic [15:0] r;
    logic h;
    logic [15:0] mask;
    #1 reset = 1'b0;
    run(16'h0, 1'b0, 5);
    tick();
    #1 reset = 1'b1;
    run(16'h1234, 1'b0, 3 * FRAME);
    run(16'h0042, 1'b0, 2 * FRAME + 3);
    run(16'h0000, 1'b0, 2 * FRAME);
    run(16'h1234, 1'b0, 2 * FRAME);
    run(16'hBEEF, 1'b1, 4 * FRAME);
    run(16'hBEEF, 1'b0, 2 * FRAME);
    run(16'h0001, 1'b0, 2 * FRAME);
    run(16'h0002, 1'b0, 3);
    run(16'h0001, 1'b0, 2 * FRAME);
    run(16'hABCD, 1'b0, 2 * FRAME);
    while (m_t != 9) run(16'hABCD, 1'b0, 1);
    tick();
    #1 async_reset();
    run(16'hABCD, 1'b0, 3);
    tick();
    #1 reset = 1'b1;
    run(16'hABCD, 1'b0, 3 * FRAME);
    r = 16'h0;
    h = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(4))
          0: mask = 16'h0000;
          1: mask = 16'h000F;
          2: mask = 16'h00FF;
          3: mask = 16'h0FFF;
          default: mask = 16'hFFFF;
        endcase
        r = 16'($urandom) & mask;
      end
      if ($urandom_range(5) == 0) h = ($urandom_range(3) == 0);
      run(r, h, 1);
      if ($urandom_range(299) == 0) begin
        tick();
        #1 async_reset();
        run(r, h, 2);
        tick();
        #1 reset = 1'b1;
      end
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
